// File: rtl/vga_timing_generator.sv
// vga_timing_generator: pixel-tick divider, column/row sweep, registered enable/hsync/vsync/tick/line/frame strobes, vblank update-grant FSM
module vga_timing_generator #(
  parameter int CLOCK_DIVIDER = 2,
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update_req,
  output logic [15:0] column,
  output logic [15:0] row,
  output logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        pixel_tick,
  output logic        line_start,
  output logic        frame_start,
  output logic        update_grant
);
  localparam int DW = $clog2(CLOCK_DIVIDER);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDER - 1);
  localparam logic [15:0] H_LAST = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [15:0] V_LAST = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [15:0] H_VIS = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS = 16'(V_VISIBLE);
  localparam logic [15:0] HS_BEG = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic adv, h_wrap, v_wrap;
  logic [15:0] column_n, row_n;
  always_comb begin
    adv = div == DIV_LAST;
    h_wrap = adv && column == H_LAST;
    v_wrap = h_wrap && row == V_LAST;
    column_n = !adv ? column : h_wrap ? 16'd0 : column + 16'd1;
    row_n = !h_wrap ? row : v_wrap ? 16'd0 : row + 16'd1;
    state_n = state == IDLE
      ? ((update_req && row_n >= V_VIS && row_n != V_LAST) ? GRANTED : IDLE)
      : ((!update_req || row_n == V_LAST) ? IDLE : GRANTED);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      column <= '0;
      row <= '0;
      enable <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      pixel_tick <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      state <= IDLE;
      update_grant <= 1'b0;
    end else begin
      div <= adv ? '0 : div + 1'b1;
      column <= column_n;
      row <= row_n;
      enable <= column_n < H_VIS && row_n < V_VIS;
      hsync <= !(column_n >= HS_BEG && column_n < HS_END);
      vsync <= !(row_n >= VS_BEG && row_n < VS_END);
      pixel_tick <= adv;
      line_start <= h_wrap;
      frame_start <= v_wrap;
      state <= state_n;
      update_grant <= state_n == GRANTED;
    end
  end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed checks of timing, strobes and update grant on default and reduced configurations
module tb_vga_timing_generator;
  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic en, hs, vs, tick, ls, fs;
  } out_t;
  typedef struct {
    int k;
    logic req;
    out_t exp;
    logic gr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic [15:0] col_a, row_a, col_b, row_b, col_c, row_c;
  logic en_a, hs_a, vs_a, tk_a, ls_a, fs_a, gr_a;
  logic en_b, hs_b, vs_b, tk_b, ls_b, fs_b, gr_b;
  logic en_c, hs_c, vs_c, tk_c, ls_c, fs_c, gr_c;
  out_t oa, ob, oc, rst_o;
  int k = 0, n_chk = 0, n_fail = 0;
  vec_t tv[12];
  always #5 clk = ~clk;
  vga_timing_generator dut_a (
    .clock(clk), .reset(rst), .update_req(req_a), .column(col_a), .row(row_a),
    .enable(en_a), .hsync(hs_a), .vsync(vs_a), .pixel_tick(tk_a),
    .line_start(ls_a), .frame_start(fs_a), .update_grant(gr_a)
  );
  vga_timing_generator #(
    .CLOCK_DIVIDER(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(3), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clock(clk), .reset(rst), .update_req(req_b), .column(col_b), .row(row_b),
    .enable(en_b), .hsync(hs_b), .vsync(vs_b), .pixel_tick(tk_b),
    .line_start(ls_b), .frame_start(fs_b), .update_grant(gr_b)
  );
  vga_timing_generator #(
    .CLOCK_DIVIDER(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_c (
    .clock(clk), .reset(rst), .update_req(req_c), .column(col_c), .row(row_c),
    .enable(en_c), .hsync(hs_c), .vsync(vs_c), .pixel_tick(tk_c),
    .line_start(ls_c), .frame_start(fs_c), .update_grant(gr_c)
  );
  assign oa = {col_a, row_a, en_a, hs_a, vs_a, tk_a, ls_a, fs_a};
  assign ob = {col_b, row_b, en_b, hs_b, vs_b, tk_b, ls_b, fs_b};
  assign oc = {col_c, row_c, en_c, hs_c, vs_c, tk_c, ls_c, fs_c};
  assign rst_o = {16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask
  function automatic vec_t mk(input int kk, input logic rq, input int c, input int r,
                              input logic en, input logic hs, input logic vs,
                              input logic tk, input logic ls, input logic fs, input logic gr);
    vec_t v;
    v.k = kk;
    v.req = rq;
    v.exp = {16'(c), 16'(r), en, hs, vs, tk, ls, fs};
    v.gr = gr;
    return v;
  endfunction
  function automatic out_t model(input int kk, input int dv, input int hv, input int hf,
                                 input int hsw, input int hb, input int vv, input int vf,
                                 input int vsw, input int vb);
    int p, c, r;
    out_t o;
    p = kk / dv;
    c = p % (hv + hf + hsw + hb);
    r = (p / (hv + hf + hsw + hb)) % (vv + vf + vsw + vb);
    o.col = 16'(c);
    o.row = 16'(r);
    o.en = c < hv && r < vv;
    o.hs = !(c >= hv + hf && c < hv + hf + hsw);
    o.vs = !(r >= vv + vf && r < vv + vf + vsw);
    o.tick = kk > 0 && kk % dv == 0;
    o.ls = o.tick && c == 0;
    o.fs = o.ls && r == 0;
    return o;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n_en, n_hs, n_tk, n_ls, fb1, fb2, fc1, fc2, early, bad, high;
    tv[0]  = mk(1,    0, 0,   0, 1, 1, 1, 0, 0, 0, 0);
    tv[1]  = mk(2,    0, 1,   0, 1, 1, 1, 1, 0, 0, 0);
    tv[2]  = mk(3,    0, 1,   0, 1, 1, 1, 0, 0, 0, 0);
    tv[3]  = mk(1279, 1, 639, 0, 1, 1, 1, 0, 0, 0, 0);
    tv[4]  = mk(1280, 1, 640, 0, 0, 1, 1, 1, 0, 0, 0);
    tv[5]  = mk(1311, 1, 655, 0, 0, 1, 1, 0, 0, 0, 0);
    tv[6]  = mk(1312, 1, 656, 0, 0, 0, 1, 1, 0, 0, 0);
    tv[7]  = mk(1503, 1, 751, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[8]  = mk(1504, 1, 752, 0, 0, 1, 1, 1, 0, 0, 0);
    tv[9]  = mk(1599, 1, 799, 0, 0, 1, 1, 0, 0, 0, 0);
    tv[10] = mk(1600, 1, 0,   1, 1, 1, 1, 1, 1, 0, 0);
    tv[11] = mk(1601, 1, 0,   1, 1, 1, 1, 0, 0, 0, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (300) step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_outputs", 64'(oa), 64'(rst_o));
      chk("reset_grant", 64'(gr_a), 64'd0);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      req_a = tv[i].req;
      while (k < tv[i].k) step();
      chk($sformatf("vec%0d", i), 64'(oa), 64'(tv[i].exp));
      chk($sformatf("vec%0d_grant", i), 64'(gr_a), 64'(tv[i].gr));
    end
    n_en = 0; n_hs = 0; n_tk = 0; n_ls = 0;
    while (k < 3201) begin
      step();
      n_en += int'(en_a);
      n_hs += int'(!hs_a);
      n_tk += int'(tk_a);
      n_ls += int'(ls_a);
    end
    chk("line_enable_clocks", 64'(n_en), 64'd1280);
    chk("line_hsync_low_clocks", 64'(n_hs), 64'd192);
    chk("line_ticks", 64'(n_tk), 64'd800);
    chk("line_starts", 64'(n_ls), 64'd1);
    chk("line2_position", {col_a, row_a}, {16'd0, 16'd2});
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    k = 0;
    fb1 = 0; fb2 = 0; fc1 = 0; fc2 = 0;
    while (k < 900) begin
      step();
      chk("b_sweep", 64'(ob), 64'(model(k, 2, 8, 2, 2, 2, 8, 3, 2, 3)));
      chk("c_sweep", 64'(oc), 64'(model(k, 4, 8, 2, 2, 2, 4, 1, 1, 1)));
      if (fs_b) begin fb1 = fb2; fb2 = k; end
      if (fs_c) begin fc1 = fc2; fc2 = k; end
    end
    chk("b_frame_len", 64'(fb2 - fb1), 64'd448);
    chk("c_frame_len", 64'(fc2 - fc1), 64'd392);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    k = 0;
    while (k < 56) step();
    req_b = 1'b1;
    early = 0;
    while (row_b != 16'd8 && k < 400) begin
      step();
      if (row_b < 16'd8 && gr_b) early++;
    end
    chk("grant_early", 64'(early), 64'd0);
    chk("grant_rise", {row_b, 15'd0, gr_b}, {16'd8, 15'd0, 1'b1});
    while (k < 280) step();
    chk("grant_row10", 64'(gr_b), 64'd1);
    req_b = 1'b0;
    step();
    chk("grant_drop", 64'(gr_b), 64'd0);
    while (k < 336) step();
    req_b = 1'b1;
    step();
    chk("regrant", {row_b, 15'd0, gr_b}, {16'd12, 15'd0, 1'b1});
    while (k < 419) step();
    chk("grant_before_revoke", {row_b, 15'd0, gr_b}, {16'd14, 15'd0, 1'b1});
    step();
    chk("forced_revoke", {row_b, 15'd0, gr_b}, {16'd15, 15'd0, 1'b0});
    bad = 0; high = 0;
    while (k < 1343) begin
      step();
      if (k >= 448) begin
        if (gr_b !== ((k / 28) % 16 >= 8 && (k / 28) % 16 <= 14)) bad++;
        high += int'(gr_b);
      end
    end
    chk("held_grant_mismatches", 64'(bad), 64'd0);
    chk("held_grant_clocks", 64'(high), 64'd392);
    while (k < 1578) step();
    chk("grant_before_reset", 64'(gr_b), 64'd1);
    rst = 1'b1;
    step();
    chk("reset_drops_grant", 64'(gr_b), 64'd0);
    chk("reset_b_outputs", 64'(ob), 64'(rst_o));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
